hilo_muldiv_unit: RTL and testbench

- Parametrised multi-cycle multiply/divide engine that produces HI/LO results for the execute stage of the 5-stage MIPS pipeline.
- Replaces the single-cycle HILO arithmetic path in the ALU.
- Adds signed/unsigned iterative division, a pipelined multiplier, a stall request to the hazard unit, and flush cancellation.
- Results go to the E->M HILO pipeline register on the done pulse.

---
 rtl/hilo_muldiv_unit.sv | 205 ++++++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply/divide engine for the execute stage.
// MULT/MULTU finish MUL_LAT edges after the start edge. DIV/DIVU use a restoring
// radix-2 divider on the operand magnitudes and finish WIDTH+1 edges after the
// start edge. The result is written to hi_o/lo_o together with a one-cycle done_o pulse.
module hilo_muldiv_unit #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cancel_i,
    output logic             busy_o,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             divzero_o
);

    localparam int unsigned CntMax = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
    localparam int unsigned CntW   = $clog2(CntMax) + 1;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    // a_q: multiplicand, or the dividend magnitude shifting out while quotient bits shift in.
    logic [WIDTH-1:0]  a_q, a_d;
    // b_q: multiplier, or the divisor magnitude.
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic              signed_q, signed_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic              done_q, done_d;
    logic              dz_q, dz_d;

    logic              is_signed_in;
    logic              a_neg;
    logic              b_neg;
    logic [WIDTH-1:0]  a_mag;
    logic [WIDTH-1:0]  b_mag;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     trial;

    // Operand conditioning at issue: op_i[0] selects unsigned, op_i[1] selects divide.
    assign is_signed_in = ~op_i[0];
    assign a_neg        = is_signed_in & a_i[WIDTH-1];
    assign b_neg        = is_signed_in & b_i[WIDTH-1];
    assign a_mag        = a_neg ? -a_i : a_i;
    assign b_mag        = b_neg ? -b_i : b_i;

    // Sign-extending to 2*WIDTH makes the low 2*WIDTH bits of an unsigned multiply
    // equal to the signed product. The inputs are latched, so the multiply can be
    // retimed across the MUL_LAT cycles.
    assign a_ext = {{WIDTH{signed_q & a_q[WIDTH-1]}}, a_q};
    assign b_ext = {{WIDTH{signed_q & b_q[WIDTH-1]}}, b_q};
    assign prod  = a_ext * b_ext;

    // Restoring step: shift the next dividend bit into the partial remainder, then
    // try to subtract the divisor.
    assign trial = {rem_q, a_q[WIDTH-1]} - {1'b0, b_q};

    // Next-state logic, latches and result write-back.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        rem_d    = rem_q;
        signed_d = signed_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dz_d     = dz_q;

        unique case (state_q)
            StIdle: begin
                if (start_i && !cancel_i) begin
                    signed_d = is_signed_in;
                    if (!op_i[1]) begin
                        a_d     = a_i;
                        b_d     = b_i;
                        cnt_d   = CntW'(MUL_LAT - 1);
                        state_d = StMul;
                    end else if (b_i == '0) begin
                        // Divide by zero finishes at the start edge itself.
                        done_d = 1'b1;
                        dz_d   = 1'b1;
                        lo_d   = '1;
                        hi_d   = a_i;
                    end else begin
                        a_d     = a_mag;
                        b_d     = b_mag;
                        rem_d   = '0;
                        qneg_d  = a_neg ^ b_neg;
                        rneg_d  = a_neg;
                        cnt_d   = CntW'(WIDTH - 1);
                        state_d = StDiv;
                    end
                end
            end

            StMul: begin
                if (cancel_i) begin
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    hi_d    = prod[2*WIDTH-1:WIDTH];
                    lo_d    = prod[WIDTH-1:0];
                    done_d  = 1'b1;
                    dz_d    = 1'b0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end

            StDiv: begin
                if (cancel_i) begin
                    state_d = StIdle;
                end else begin
                    if (!trial[WIDTH]) begin
                        rem_d = trial[WIDTH-1:0];
                        a_d   = {a_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = {rem_q[WIDTH-2:0], a_q[WIDTH-1]};
                        a_d   = {a_q[WIDTH-2:0], 1'b0};
                    end
                    if (cnt_q == '0) begin
                        state_d = StFix;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
            end

            StFix: begin
                if (cancel_i) begin
                    state_d = StIdle;
                end else begin
                    // The most-negative / -1 case wraps naturally: the quotient magnitude
                    // 2^(WIDTH-1) negates to itself.
                    lo_d    = qneg_q ? -a_q : a_q;
                    hi_d    = rneg_q ? -rem_q : rem_q;
                    done_d  = 1'b1;
                    dz_d    = 1'b0;
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; asynchronous reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            signed_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rem_q    <= rem_d;
            signed_q <= signed_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
        end
    end

    // The stall is combinational so the issuing instruction holds in E from its first
    // cycle. It drops in the done cycle so the instruction can capture hi_o/lo_o.
    assign stall_o   = (state_q == StIdle) ? (start_i & ~cancel_i) : 1'b1;
    assign busy_o    = (state_q != StIdle);
    assign done_o    = done_q;
    assign hi_o      = hi_q;
    assign lo_o      = lo_q;
    assign divzero_o = dz_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit (WIDTH=32, MUL_LAT=2): a table of vectors plus hand
// sequences. Expected results are queued at issue and compared on done_o.
module tb_hilo_muldiv_unit;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst;
    logic         start_i;
    logic [1:0]   op_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         cancel_i;
    logic         busy_o;
    logic         stall_o;
    logic         done_o;
    logic [W-1:0] hi_o;
    logic [W-1:0] lo_o;
    logic         divzero_o;

    hilo_muldiv_unit #(.WIDTH(W), .MUL_LAT(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .cancel_i (cancel_i),
        .busy_o   (busy_o),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .hi_o     (hi_o),
        .lo_o     (lo_o),
        .divzero_o(divzero_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [1:0] OpMult  = 2'b00;
    localparam logic [1:0] OpMultu = 2'b01;
    localparam logic [1:0] OpDiv   = 2'b10;
    localparam logic [1:0] OpDivu  = 2'b11;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           lat;
    } vec_t;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && done_o) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'(done_o), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_hi", 64'(hi_o), 64'(e.hi));
                check("sb_lo", 64'(lo_o), 64'(e.lo));
                check("sb_divzero", 64'(divzero_o), 64'(e.dz));
            end
        end
    end

    task automatic push_exp(input logic [W-1:0] hi, input logic [W-1:0] lo, input logic dz);
        exp_t e;
        e.hi = hi;
        e.lo = lo;
        e.dz = dz;
        sb.push_back(e);
    endtask

    // Counts posedges after the start edge until done_o, with a bound.
    task automatic wait_done(inout int edges);
        while (!done_o && edges < 100) begin
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] hi, input logic [W-1:0] lo, input logic dz,
                          input int lat);
        int edges;
        @(negedge clk);
        start_i = 1'b1;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        push_exp(hi, lo, dz);
        #1;
        check("stall_on_start", 64'(stall_o), 64'd1);
        @(negedge clk);
        start_i = 1'b0;
        #1;
        edges = 0;
        wait_done(edges);
        check("latency", 64'(edges), 64'(lat));
        check("stall_in_done", 64'(stall_o), 64'd0);
    endtask

    vec_t vecs[12];

    initial begin
        int edges;
        logic saw_done;

        vecs[0]  = '{OpMult,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 2};
        vecs[1]  = '{OpMultu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 2};
        vecs[2]  = '{OpDiv,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
        vecs[3]  = '{OpDivu,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33};
        vecs[4]  = '{OpDiv,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 33};
        vecs[5]  = '{OpDivu,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1, 0};
        vecs[6]  = '{OpDivu,  32'd50,       32'd5,        32'd0,        32'd10,       1'b0, 33};
        vecs[7]  = '{OpDiv,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 33};
        vecs[8]  = '{OpMult,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 2};
        vecs[9]  = '{OpDiv,   32'd0,        32'd5,        32'd0,        32'd0,        1'b0, 33};
        vecs[10] = '{OpDiv,   32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1, 0};
        vecs[11] = '{OpMultu, 32'h12345678, 32'h10,       32'h1,        32'h23456780, 1'b0, 2};

        rst      = 1'b0;
        start_i  = 1'b0;
        op_i     = 2'b00;
        a_i      = '0;
        b_i      = '0;
        cancel_i = 1'b0;
        #1;
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_stall", 64'(stall_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_hilo", {hi_o, lo_o}, 64'd0);
        check("rst_divzero", 64'(divzero_o), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Table-driven vectors; after each done, the result must hold and done must drop.
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz,
                   vecs[i].lat);
            @(negedge clk);
            check("done_one_cycle", 64'(done_o), 64'd0);
            check("hold_hilo", {hi_o, lo_o}, {vecs[i].hi, vecs[i].lo});
            check("hold_divzero", 64'(divzero_o), 64'(vecs[i].dz));
        end

        // Back-to-back issue in the done cycle.
        run_op(OpMultu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 1'b0, 2);
        start_i = 1'b1;
        op_i    = OpMultu;
        a_i     = 32'd3;
        b_i     = 32'd5;
        push_exp(32'd0, 32'd15, 1'b0);
        #1;
        check("b2b_stall", 64'(stall_o), 64'd1);
        @(negedge clk);
        start_i = 1'b0;
        edges   = 0;
        wait_done(edges);
        check("b2b_latency", 64'(edges), 64'd2);

        // Cancel mid-divide: no done, previous results preserved.
        run_op(OpDivu, 32'h2211, 32'h100, 32'h11, 32'h22, 1'b0, 33);
        @(negedge clk);
        start_i = 1'b1;
        op_i    = OpDiv;
        a_i     = 32'd1000;
        b_i     = 32'd3;
        @(negedge clk);
        start_i = 1'b0;
        repeat (9) @(negedge clk);
        cancel_i = 1'b1;
        @(negedge clk);
        cancel_i = 1'b0;
        check("cancel_busy", 64'(busy_o), 64'd0);
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done_o) saw_done = 1'b1;
        end
        check("cancel_no_done", 64'(saw_done), 64'd0);
        check("cancel_hilo", {hi_o, lo_o}, {32'h11, 32'h22});
        check("cancel_divzero", 64'(divzero_o), 64'd0);

        // start_i pulsed mid-divide is ignored.
        @(negedge clk);
        start_i = 1'b1;
        op_i    = OpDivu;
        a_i     = 32'd100;
        b_i     = 32'd7;
        push_exp(32'd2, 32'd14, 1'b0);
        @(negedge clk);
        start_i = 1'b0;
        repeat (4) @(negedge clk);
        start_i = 1'b1;
        op_i    = OpMult;
        a_i     = 32'd9;
        b_i     = 32'd9;
        #1;
        check("mid_start_stall", 64'(stall_o), 64'd1);
        @(negedge clk);
        start_i = 1'b0;
        edges   = 5;
        wait_done(edges);
        check("mid_start_latency", 64'(edges), 64'd33);

        // cancel_i and start_i together in IDLE: nothing starts.
        @(negedge clk);
        start_i  = 1'b1;
        cancel_i = 1'b1;
        op_i     = OpMult;
        a_i      = 32'd2;
        b_i      = 32'd2;
        #1;
        check("cancel_start_stall", 64'(stall_o), 64'd0);
        @(negedge clk);
        start_i  = 1'b0;
        cancel_i = 1'b0;
        check("cancel_start_busy", 64'(busy_o), 64'd0);

        // Asynchronous reset between edges mid-divide.
        @(negedge clk);
        start_i = 1'b1;
        op_i    = OpDiv;
        a_i     = 32'hFFFFFFF9;
        b_i     = 32'd2;
        push_exp(32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        @(negedge clk);
        start_i = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_busy", 64'(busy_o), 64'd0);
        check("arst_stall", 64'(stall_o), 64'd0);
        check("arst_done", 64'(done_o), 64'd0);
        check("arst_hilo", {hi_o, lo_o}, 64'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        run_op(OpMult, 32'd6, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0, 2);

        @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
